// File: rtl/sprite_sequencer.sv
// Multi-channel sprite redraw engine: per frame tick, erases each channel's previous
// footprint and redraws it at its new position, one pixel strobe per scan cycle.
module sprite_sequencer #(
   parameter int NUM_SPRITES = 7,
   parameter int SPR_W       = 6,
   parameter int SPR_H       = 7,
   parameter int X_W         = 8,
   parameter int Y_W         = 7,
   parameter int SCREEN_W    = 160,
   parameter int SCREEN_H    = 120,
   parameter int COLOUR_W    = 3
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            frame_tick,
   input  logic [NUM_SPRITES-1:0]          sprite_en,
   input  logic [NUM_SPRITES*X_W-1:0]      sprite_x,
   input  logic [NUM_SPRITES*Y_W-1:0]      sprite_y,
   input  logic [NUM_SPRITES*COLOUR_W-1:0] sprite_colour,
   input  logic [SPR_W*SPR_H-1:0]          sprite_mask,
   input  logic [COLOUR_W-1:0]             bg_colour,
   output logic [X_W-1:0]                  x_out,
   output logic [Y_W-1:0]                  y_out,
   output logic [COLOUR_W-1:0]             colour_out,
   output logic                            plot,
   output logic                            busy,
   output logic                            pass_done,
   output logic                            overrun
);

   localparam int P     = SPR_W * SPR_H;
   localparam int CH_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int C_W   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int R_W   = (SPR_H > 1) ? $clog2(SPR_H) : 1;
   localparam int PIX_W = (P > 1) ? $clog2(P) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SELECT = 3'd1,
      S_ERASE  = 3'd2,
      S_DRAW   = 3'd3,
      S_NEXT   = 3'd4,
      S_DONE   = 3'd5
   } state_e;

   state_e               state_q, state_d;
   logic [CH_W-1:0]      ch_q, ch_d;
   logic [C_W-1:0]       c_q, c_d;
   logic [R_W-1:0]       r_q, r_d;
   logic [PIX_W-1:0]     pix_q, pix_d;

   logic [NUM_SPRITES-1:0] en_q;
   logic [X_W-1:0]         x_q      [NUM_SPRITES];
   logic [Y_W-1:0]         y_q      [NUM_SPRITES];
   logic [COLOUR_W-1:0]    col_q    [NUM_SPRITES];
   logic [P-1:0]           mask_q;
   logic [COLOUR_W-1:0]    bg_q;
   logic [X_W-1:0]         old_x_q  [NUM_SPRITES];
   logic [Y_W-1:0]         old_y_q  [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] old_valid_q;
   logic                   overrun_q;

   logic                   load_s;
   logic                   scan_last_s;
   logic                   scanning_s;
   logic [X_W-1:0]         base_x_s;
   logic [Y_W-1:0]         base_y_s;
   logic [X_W:0]           sum_x_s;
   logic [Y_W:0]           sum_y_s;

   assign load_s      = (state_q == S_IDLE) && frame_tick;
   assign scan_last_s = (pix_q == PIX_W'(P - 1));
   assign scanning_s  = (state_q == S_ERASE) || (state_q == S_DRAW);
   assign base_x_s    = (state_q == S_ERASE) ? old_x_q[ch_q] : x_q[ch_q];
   assign base_y_s    = (state_q == S_ERASE) ? old_y_q[ch_q] : y_q[ch_q];
   // One extra bit keeps off-screen sums from wrapping back onto the visible area.
   assign sum_x_s     = {1'b0, base_x_s} + (X_W+1)'(c_q);
   assign sum_y_s     = {1'b0, base_y_s} + (Y_W+1)'(r_q);

   assign busy        = (state_q != S_IDLE);
   assign pass_done   = (state_q == S_DONE);
   assign overrun     = overrun_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ch_q        <= {CH_W{1'b0}};
         c_q         <= {C_W{1'b0}};
         r_q         <= {R_W{1'b0}};
         pix_q       <= {PIX_W{1'b0}};
         en_q        <= {NUM_SPRITES{1'b0}};
         mask_q      <= {P{1'b0}};
         bg_q        <= {COLOUR_W{1'b0}};
         old_valid_q <= {NUM_SPRITES{1'b0}};
         overrun_q   <= 1'b0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            x_q[i]     <= {X_W{1'b0}};
            y_q[i]     <= {Y_W{1'b0}};
            col_q[i]   <= {COLOUR_W{1'b0}};
            old_x_q[i] <= {X_W{1'b0}};
            old_y_q[i] <= {Y_W{1'b0}};
         end
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         c_q       <= c_d;
         r_q       <= r_d;
         pix_q     <= pix_d;
         overrun_q <= frame_tick && (state_q != S_IDLE);
         if (load_s) begin
            en_q   <= sprite_en;
            mask_q <= sprite_mask;
            bg_q   <= bg_colour;
            for (int i = 0; i < NUM_SPRITES; i++) begin
               x_q[i]   <= sprite_x[i*X_W +: X_W];
               y_q[i]   <= sprite_y[i*Y_W +: Y_W];
               col_q[i] <= sprite_colour[i*COLOUR_W +: COLOUR_W];
            end
         end
         // Commit the drawn position so the next pass knows what to erase.
         if (state_q == S_NEXT) begin
            old_x_q[ch_q]     <= x_q[ch_q];
            old_y_q[ch_q]     <= y_q[ch_q];
            old_valid_q[ch_q] <= en_q[ch_q];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      c_d     = c_q;
      r_d     = r_q;
      pix_d   = pix_q;
      case (state_q)
         S_IDLE: begin
            if (frame_tick) begin
               state_d = S_SELECT;
               ch_d    = {CH_W{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SELECT: begin
            c_d   = {C_W{1'b0}};
            r_d   = {R_W{1'b0}};
            pix_d = {PIX_W{1'b0}};
            if (old_valid_q[ch_q]) begin
               state_d = S_ERASE;
            end else if (en_q[ch_q]) begin
               state_d = S_DRAW;
            end else begin
               state_d = S_NEXT;
            end
         end
         S_ERASE, S_DRAW: begin
            if (scan_last_s) begin
               c_d   = {C_W{1'b0}};
               r_d   = {R_W{1'b0}};
               pix_d = {PIX_W{1'b0}};
               if ((state_q == S_ERASE) && en_q[ch_q]) begin
                  state_d = S_DRAW;
               end else begin
                  state_d = S_NEXT;
               end
            end else begin
               pix_d = pix_q + PIX_W'(1);
               if (c_q == C_W'(SPR_W - 1)) begin
                  c_d = {C_W{1'b0}};
                  r_d = r_q + R_W'(1);
               end else begin
                  c_d = c_q + C_W'(1);
               end
            end
         end
         S_NEXT: begin
            if (ch_q == CH_W'(NUM_SPRITES - 1)) begin
               state_d = S_DONE;
            end else begin
               ch_d    = ch_q + CH_W'(1);
               state_d = S_SELECT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      x_out      = {X_W{1'b0}};
      y_out      = {Y_W{1'b0}};
      colour_out = {COLOUR_W{1'b0}};
      plot       = 1'b0;
      if (scanning_s) begin
         x_out      = sum_x_s[X_W-1:0];
         y_out      = sum_y_s[Y_W-1:0];
         colour_out = (state_q == S_ERASE) ? bg_q : col_q[ch_q];
         plot       = mask_q[pix_q]
                      && (sum_x_s < (X_W+1)'(SCREEN_W))
                      && (sum_y_s < (Y_W+1)'(SCREEN_H));
      end else begin
         plot       = 1'b0;
      end
   end

endmodule

// File: doc/sprite_sequencer.md
SPRITE_SEQUENCER -- requirements
Module: sprite_sequencer

Interface
REQ-001 Parameter NUM_SPRITES, 7: number of sprite channels; range 1..16.
REQ-002 Parameter SPR_W, 6: sprite bitmap width in pixels.
REQ-003 Parameter SPR_H, 7: sprite bitmap height in pixels.
REQ-004 Parameters X_W and Y_W, 8 and 7: coordinate widths.
REQ-005 Parameters SCREEN_W and SCREEN_H, 160 and 120: visible area used for clipping.
REQ-006 Parameter COLOUR_W, 3: colour width.
REQ-007 Port `clock`: input, 1 bit; the single clock; all state changes on its rising edge.
REQ-008 Port `reset`: input, 1 bit; synchronous, active-high.
REQ-009 Port `frame_tick`: input, 1 bit; one-cycle pulse that requests a redraw pass.
REQ-010 Port `sprite_en`: input, NUM_SPRITES bits; bit i enables channel i for drawing.
REQ-011 Port `sprite_x`: input, NUM_SPRITES*X_W bits; top-left x of channel i at bits [i*X_W +: X_W].
REQ-012 Port `sprite_y`: input, NUM_SPRITES*Y_W bits; top-left y of channel i, packed the same way as `sprite_x`.
REQ-013 Port `sprite_colour`: input, NUM_SPRITES*COLOUR_W bits; draw colour of channel i.
REQ-014 Port `sprite_mask`: input, SPR_W*SPR_H bits; shared bitmap; bit r*SPR_W+c set means pixel (c,r) is opaque.
REQ-015 Port `bg_colour`: input, COLOUR_W bits; colour used for erasing.
REQ-016 Port `x_out`: output, X_W bits; pixel x. Port `y_out`: output, Y_W bits; pixel y.
REQ-017 Port `colour_out`: output, COLOUR_W bits; pixel colour. Port `plot`: output, 1 bit; write strobe for the pixel.
REQ-018 Port `busy`: output, 1 bit; high whenever the block is not in IDLE.
REQ-019 Port `pass_done`: output, 1 bit; one-cycle pulse when a pass completes.
REQ-020 Port `overrun`: output, 1 bit; one-cycle pulse when `frame_tick` arrives while `busy` is high.

Function
REQ-021 States SHALL be IDLE, SELECT, ERASE, DRAW, NEXT and DONE.
REQ-022 In IDLE, a clock edge with `frame_tick`=1 SHALL snapshot `sprite_en`, `sprite_x`, `sprite_y`, `sprite_colour`, `sprite_mask` and `bg_colour`, set ch=0, and enter SELECT.
- Inputs SHALL be ignored until the next pass.
REQ-023 SELECT SHALL last 1 cycle and branch as follows:
- `old_valid[ch]` set: go to ERASE.
- else snapshot `en[ch]` set: go to DRAW.
- else: go to NEXT.
REQ-024 ERASE and DRAW SHALL each last exactly SPR_W*SPR_H cycles.
- Scan uses counters c and r; c increments fastest.
- Scan starts at (0,0) and ends at (SPR_W-1, SPR_H-1).
REQ-025 ERASE SHALL output, combinationally from state and counters:
- `x_out` = old_x[ch]+c and `y_out` = old_y[ch]+r;
- `colour_out` = snapshot `bg_colour`.
REQ-026 DRAW SHALL output, combinationally from state and counters:
- `x_out` = new_x[ch]+c and `y_out` = new_y[ch]+r;
- `colour_out` = snapshot `sprite_colour[ch]`.
REQ-027 During ERASE/DRAW, `plot` SHALL be 1 only if the mask bit at (c,r) is set AND the pixel is on screen.
- On screen means the sum x+c < SCREEN_W and y+r < SCREEN_H.
- Sums SHALL be computed at X_W+1 and Y_W+1 bits so no wrap-around occurs.
REQ-028 A clipped or transparent pixel SHALL still consume its cycle, so timing is data-independent.
REQ-029 Leaving ERASE SHALL go to DRAW if `en[ch]` is set, else to NEXT.
- Leaving DRAW SHALL go to NEXT.
REQ-030 NEXT SHALL last 1 cycle.
- It SHALL set old_x[ch] and old_y[ch] from the new position and old_valid[ch] from `en[ch]`.
- If ch=NUM_SPRITES-1 it SHALL go to DONE; else it SHALL increment ch and go to SELECT.
REQ-031 DONE SHALL assert `pass_done` for exactly 1 cycle, then return to IDLE.
REQ-032 Outside ERASE/DRAW, `plot` SHALL be 0 and `x_out`, `y_out`, `colour_out` SHALL be 0.
REQ-033 A `frame_tick` while not in IDLE SHALL be dropped, SHALL pulse `overrun` on the same edge, and SHALL NOT alter the pass.
REQ-034 Pass length SHALL equal 2 + sum over channels of (2 + P*erase_i + P*draw_i) cycles, where P=SPR_W*SPR_H.
- The 2 counts the tick edge and DONE.
- erase_i and draw_i are 0 or 1 for each channel.

Reset
REQ-035 `reset`=1 at a clock edge SHALL force IDLE, from any state including mid-scan.
- It SHALL clear ch, c, r, all old_valid, old_x and old_y, and all snapshots to 0.
REQ-036 During and after reset, `plot`, `busy`, `pass_done`, `overrun`, `x_out`, `y_out` and `colour_out` SHALL be 0.
- Stale on-screen pixels are not erased; the display reset is responsible for them.
REQ-037 `reset` SHALL take priority over a simultaneous `frame_tick`.

Verification
REQ-038 Setup: NUM_SPRITES=2, SPR_W=SPR_H=2, full mask, ch0 enabled at (10,20) with colour 7; tick after reset.
- `plot` SHALL be high on cycles 2-5 at (10,20), (11,20), (10,21), (11,21) with colour 7.
- ch1 SHALL be skipped, and `pass_done` SHALL pulse on cycle 9.
REQ-039 Second tick with ch0 moved to (12,20) and `bg_colour`=0.
- First, 4 erase plots at the old pixels with colour 0; then 4 draw plots at x=12..13.
- `pass_done` SHALL pulse on cycle 13.
REQ-040 Clipping: ch0 at (159,119).
- Exactly 1 plot at (159,119); the other 3 cycles have `plot`=0; pass length is unchanged.
REQ-041 Mask 4'b0110: plots occur only at (c,r) = (1,0) and (0,1), each in its own scan cycle.
REQ-042 Tick while mid-DRAW: `overrun` SHALL pulse, and the pass SHALL complete unchanged.
REQ-043 Reset asserted mid-ERASE: outputs SHALL be 0 next cycle.
- The next tick SHALL draw without erasing, because all old_valid are cleared.
